seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the 16-bit combinational ALU. It keeps the same 16-mode operation map and widens the datapath to N bits. Shifts take a variable amount (low bits of B) and run one bit position per clock. Operands enter and results leave through valid/ready handshakes, so the block can sit between a register-file read stage and a writeback stage that may stall.

---
 rtl/seq_alu.sv | 204 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle N-bit ALU with a 16-mode map; shifts advance one bit position per clock.
// Result registers load 1+s cycles after accept and hold steady while out_ready is low; in_ready only in IDLE.
module seq_alu #(
  parameter  int N  = 16,
  localparam int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic [3:0]   Mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic         Cout,
  output logic         Overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [3:0]   mode;
  } op_t;

  state_t        state;
  op_t           op;
  logic [N-1:0]  work;
  logic [SW-1:0] cnt;
  logic          sh_out;
  logic          sh_ovf;

  logic [N-1:0]  add_b;
  logic          add_cin;
  logic [N-1:0]  add_s;
  logic          add_co;
  logic          add_ovf;
  logic [SW-1:0] enc;
  logic [N-1:0]  res_y;
  logic          res_c;
  logic          res_v;

  assign in_ready = (state == IDLE);

  // Subtraction reuses the adder as A + ~B + 1.
  assign add_b   = (op.mode == 4'd5) ? ~op.b : op.b;
  assign add_cin = (op.mode == 4'd5) ? 1'b1  : op.cin;

  // Lookahead inside each 4-bit group, group carries rippled between groups.
  always_comb begin
    logic [3:0] ga;
    logic [3:0] gb;
    logic [3:0] gg;
    logic [3:0] gp;
    logic [4:0] c;
    logic       carry;
    ga    = '0;
    gb    = '0;
    gg    = '0;
    gp    = '0;
    c     = '0;
    carry = add_cin;
    add_s = '0;
    for (int g = 0; g < N / 4; g++) begin
      ga   = op.a[4*g +: 4];
      gb   = add_b[4*g +: 4];
      gg   = ga & gb;
      gp   = ga ^ gb;
      c[0] = carry;
      c[1] = gg[0] | (gp[0] & c[0]);
      c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
      c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
           | (gp[2] & gp[1] & gp[0] & c[0]);
      c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
           | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & c[0]);
      add_s[4*g +: 4] = gp ^ c[3:0];
      carry = c[4];
    end
    add_co = carry;
  end

  assign add_ovf = (op.a[N-1] == add_b[N-1]) && (add_s[N-1] != op.a[N-1]);

  always_comb begin
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (op.a[i]) enc = SW'(i);
    end
  end

  always_comb begin
    res_y = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op.mode)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        res_y = work;
        res_c = sh_out;
        res_v = sh_ovf;
      end
      4'd4, 4'd5: begin
        res_y = add_s;
        res_c = add_co;
        res_v = add_ovf;
      end
      4'd6:  res_y = op.a & op.b;
      4'd7:  res_y = op.a | op.b;
      4'd8:  res_y = ~op.a;
      4'd9:  res_y = op.a ^ op.b;
      4'd10: res_y = ~(op.a ^ op.b);
      4'd11: res_y = ~(op.a | op.b);
      4'd12: res_y = {{(N-1){1'b0}}, 1'b1} << op.a[SW-1:0];
      4'd13: res_y = {{(N-3){1'b0}}, (op.a < op.b), (op.a == op.b), (op.a > op.b)};
      4'd14: res_y = op.b;
      4'd15: begin
        res_y = {{(N-SW){1'b0}}, enc};
        res_v = ~|op.a;
      end
      default: begin
        res_y = '0;
        res_c = 1'b0;
        res_v = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= '0;
      work      <= '0;
      cnt       <= '0;
      sh_out    <= 1'b0;
      sh_ovf    <= 1'b0;
      Y         <= '0;
      Cout      <= 1'b0;
      Overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op     <= '{a: A, b: B, cin: Cin, mode: Mode};
            work   <= A;
            cnt    <= (Mode[3:2] == 2'b00) ? B[SW-1:0] : '0;
            sh_out <= 1'b0;
            sh_ovf <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - SW'(1);
            case (op.mode[1:0])
              2'd0: begin
                sh_out <= work[N-1];
                work   <= {work[N-2:0], 1'b0};
              end
              2'd1: begin
                sh_out <= work[N-1];
                work   <= {work[N-2:0], 1'b0};
                if (work[N-1] != work[N-2]) sh_ovf <= 1'b1;
              end
              2'd2: begin
                sh_out <= work[0];
                work   <= {1'b0, work[N-1:1]};
              end
              default: begin
                sh_out <= work[0];
                work   <= {work[N-1], work[N-1:1]};
              end
            endcase
          end else begin
            Y         <= res_y;
            Cout      <= res_c;
            Overflow  <= res_v;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: 16-bit and 32-bit instances against an arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_alu;

  typedef struct packed {
    logic [63:0] y;
    logic        c;
    logic        v;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic [3:0]  mode;
  logic [31:0] a;
  logic [31:0] b;

  logic        rdy16, ov16, co16, vf16;
  logic        rdy32, ov32, co32, vf32;
  logic [15:0] y16;
  logic [31:0] y32;

  logic        obs_rdy, obs_ov, obs_co, obs_vf;
  logic [31:0] obs_y;

  logic [31:0] last_y;
  logic        last_c, last_v;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_alu #(.N(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel), .in_ready(rdy16),
    .A(a[15:0]), .B(b[15:0]), .Cin(cin), .Mode(mode),
    .out_valid(ov16), .out_ready(out_ready),
    .Y(y16), .Cout(co16), .Overflow(vf16)
  );

  seq_alu #(.N(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel), .in_ready(rdy32),
    .A(a), .B(b), .Cin(cin), .Mode(mode),
    .out_valid(ov32), .out_ready(out_ready),
    .Y(y32), .Cout(co32), .Overflow(vf32)
  );

  assign obs_rdy = sel ? rdy32 : rdy16;
  assign obs_ov  = sel ? ov32  : ov16;
  assign obs_co  = sel ? co32  : co16;
  assign obs_vf  = sel ? vf32  : vf16;
  assign obs_y   = sel ? y32   : {16'h0, y16};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the operation map stated directly with 64-bit arithmetic.
  function automatic res_t model(input int w, input logic [3:0] md,
                                 input longint unsigned av, input longint unsigned bv,
                                 input bit ci);
    res_t r;
    longint unsigned m, t, nb, y;
    longint sx;
    int s;
    m  = (64'd1 << w) - 1;
    av = av & m;
    bv = bv & m;
    s  = int'(bv % longint'(w));
    y  = 0;
    r  = '0;
    case (md)
      4'd0, 4'd1: begin
        if (s == 0) y = av;
        else begin
          y   = (av << s) & m;
          r.c = av[w-s];
          t   = av >> (w - 1 - s);
          if (md == 4'd1) r.v = !(t == 0 || t == ((64'd1 << (s + 1)) - 1));
        end
      end
      4'd2: begin
        y = av >> s;
        if (s != 0) r.c = av[s-1];
      end
      4'd3: begin
        sx = longint'(av << (64 - w));
        sx = sx >>> (64 - w + s);
        y  = longint'(sx) & m;
        if (s != 0) r.c = av[s-1];
      end
      4'd4, 4'd5: begin
        nb  = (md == 4'd5) ? (~bv & m) : bv;
        t   = av + nb + ((md == 4'd5) ? 64'd1 : longint'(ci));
        y   = t & m;
        r.c = t[w];
        r.v = (av[w-1] == nb[w-1]) && (y[w-1] != av[w-1]);
      end
      4'd6:  y = av & bv;
      4'd7:  y = av | bv;
      4'd8:  y = ~av & m;
      4'd9:  y = av ^ bv;
      4'd10: y = ~(av ^ bv) & m;
      4'd11: y = ~(av | bv) & m;
      4'd12: y = 64'd1 << (av % longint'(w));
      4'd13: y = (av > bv) ? 64'd1 : (av == bv) ? 64'd2 : 64'd4;
      4'd14: y = bv;
      default: begin
        for (int i = 0; i < w; i++) if (av[i]) y = longint'(i);
        r.v = (av == 0);
      end
    endcase
    r.y = y;
    return r;
  endfunction

  task automatic issue(input bit s, input logic [3:0] md, input logic [31:0] av,
                       input logic [31:0] bv, input bit ci);
    int n;
    n   = 0;
    sel = s;
    #1;
    while (!obs_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_ready", obs_rdy, 1);
    mode = md; a = av; b = bv; cin = ci;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; pend=1 presents a new operand bundle during the hold.
  task automatic collect(input bit s, input logic [3:0] md, input logic [31:0] av,
                         input logic [31:0] bv, input bit ci, input int hold, input bit pend);
    res_t r;
    int   w, lat, exp_lat;
    w   = s ? 32 : 16;
    r   = model(w, md, av, bv, ci);
    exp_lat = (md < 4'd4) ? 1 + int'(bv & (w - 1)) : 1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!obs_ov && lat < 80);
    chk("latency", lat, exp_lat);
    chk("y", obs_y, r.y);
    chk("cout", obs_co, r.c);
    chk("ovf", obs_vf, r.v);
    last_y = obs_y; last_c = obs_co; last_v = obs_vf;
    if (pend) begin
      a = ~av; b = bv; mode = md; cin = ci;
      in_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_y", obs_y, r.y);
      chk("hold_cout", obs_co, r.c);
      chk("hold_ovf", obs_vf, r.v);
      chk("hold_ready", obs_rdy, 0);
      chk("hold_valid", obs_ov, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("take_valid", obs_ov, 0);
    chk("take_ready", obs_rdy, 1);
  endtask

  task automatic dir(input bit s, input logic [3:0] md, input logic [31:0] av,
                     input logic [31:0] bv, input bit ci,
                     input logic [31:0] ey, input bit ec, input bit ev);
    issue(s, md, av, bv, ci);
    collect(s, md, av, bv, ci, 0, 1'b0);
    chk("dir_y", last_y, ey);
    chk("dir_cout", last_c, ec);
    chk("dir_ovf", last_v, ev);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cin = 1'b0; mode = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy16", rdy16, 1);
    chk("rst_ov16", ov16, 0);
    chk("rst_y16", y16, 0);
    chk("rst_rdy32", rdy32, 1);
    chk("rst_ov32", ov32, 0);
    chk("rst_y32", y32, 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset while shifting discards the operation.
    issue(0, 4'd0, 32'h0001, 32'd15, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", ov16, 0);
    chk("midrst_y", y16, 0);
    chk("midrst_ready", rdy16, 1);
    chk("midrst_cout", co16, 0);
    @(negedge clk) rst_n = 1'b1;
    dir(0, 4'd4, 32'h0012, 32'h0034, 0, 32'h0046, 0, 0);

    dir(0, 4'd4, 32'h7FFF, 32'h0001, 0, 32'h8000, 0, 1);
    dir(0, 4'd4, 32'hFFFF, 32'h0001, 1, 32'h0001, 1, 0);
    dir(0, 4'd5, 32'h0003, 32'h0005, 0, 32'hFFFE, 0, 0);
    dir(0, 4'd5, 32'h8000, 32'h0001, 0, 32'h7FFF, 1, 1);
    dir(0, 4'd3, 32'h8004, 32'd3, 0, 32'hF000, 1, 0);
    dir(0, 4'd1, 32'h4000, 32'd1, 0, 32'h8000, 0, 1);
    dir(0, 4'd2, 32'h1234, 32'd0, 0, 32'h1234, 0, 0);
    dir(0, 4'd15, 32'h0200, 32'd0, 0, 32'd9, 0, 0);
    dir(0, 4'd15, 32'h0000, 32'd0, 0, 32'd0, 0, 1);
    dir(0, 4'd12, 32'h0005, 32'd0, 0, 32'h0020, 0, 0);
    dir(0, 4'd13, 32'd5, 32'd9, 0, 32'h0004, 0, 0);
    dir(1, 4'd15, 32'h0200, 32'd0, 0, 32'd9, 0, 0);
    dir(1, 4'd15, 32'h8000_0000, 32'd0, 0, 32'd31, 0, 0);
    dir(1, 4'd15, 32'h0, 32'd0, 0, 32'd0, 0, 1);
    dir(1, 4'd12, 32'h0005, 32'd0, 0, 32'h0020, 0, 0);
    dir(1, 4'd13, 32'd5, 32'd9, 0, 32'h0004, 0, 0);
    dir(1, 4'd0, 32'h0000_0003, 32'd31, 0, 32'h8000_0000, 1, 0);

    // Backpressure with a new bundle waiting; it is accepted one cycle after the take.
    issue(0, 4'd4, 32'h1111, 32'h2222, 0);
    collect(0, 4'd4, 32'h1111, 32'h2222, 0, 5, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pend_accepted", rdy16, 0);
    collect(0, 4'd4, ~32'h1111, 32'h2222, 0, 0, 1'b0);

    for (int k = 0; k < 250; k++) begin
      logic       s;
      logic [3:0] md;
      bit         ci;
      int         hold;
      s  = 1'($urandom_range(0, 1));
      md = 4'($urandom_range(0, 15));
      ci = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = '0;
        2: ra = '1;
        default: ra = 32'h1 << $urandom_range(0, 31);
      endcase
      case ($urandom_range(0, 3))
        0, 1: rb = $urandom;
        2: rb = '1;
        default: rb = 32'h1 << $urandom_range(0, 31);
      endcase
      hold = $urandom_range(0, 2);
      issue(s, md, ra, rb, ci);
      collect(s, md, ra, rb, ci, hold, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
